// File: rtl/cofre_lock_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_lock_controller_if
//  Description : Signal bundle between the safe's user-facing inputs (confirm
//                button, close request, validator verdict) and the lock
//                controller's registered status and actuator outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cofre_lock_controller_if;
    logic       B;            // confirm button, level
    logic       FECHAR;       // close request, level
    logic       senha_ok;     // validator verdict, valid in the same cycle as B
    logic [1:0] state;        // 00=AB open, 01=FE closed, 10=BL blocked
    logic [1:0] error_count;  // consecutive wrong attempts
    logic       SPA;          // password programmed
    logic       tranca;       // bolt engaged
    logic       alarme;       // alarm active while blocked

    // Environment side: drives the user inputs, observes the controller
    modport master (
        output B, FECHAR, senha_ok,
        input  state, error_count, SPA, tranca, alarme
    );

    // Controller side
    modport slave (
        input  B, FECHAR, senha_ok,
        output state, error_count, SPA, tranca, alarme
    );
endinterface
`default_nettype wire

// File: rtl/cofre_lock_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_lock_controller
//  Description : Main sequencer for the safe. Tracks open/closed/blocked state,
//                the consecutive-error counter and the password-programmed
//                flag (SPA); drives the bolt and the alarm. All outputs are
//                registered.
//  Options     : LOCKOUT_TIMER_EN - when defined, BL releases to FE after
//                LOCKOUT_CYCLES clocks; otherwise only reset leaves BL.
//  Revision    : 1.0 - initial release
// ============================================================================
module cofre_lock_controller #(
    parameter int MAX_ERRORS     = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    cofre_lock_controller_if.slave  bus
);

    localparam logic [1:0] c_ST_AB  = 2'b00;
    localparam logic [1:0] c_ST_FE  = 2'b01;
    localparam logic [1:0] c_ST_BL  = 2'b10;
    localparam logic [1:0] c_MAX_ERR = 2'(MAX_ERRORS);

    // Parameter sanity: the counter is two bits wide, the timer needs a period
    if ((MAX_ERRORS < 1) || (MAX_ERRORS > 3)) begin : g_bad_max_errors
        $error("cofre_lock_controller: MAX_ERRORS must be in 1..3");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
        $error("cofre_lock_controller: LOCKOUT_CYCLES must be >= 1");
    end

    logic [1:0] r_state;
    logic [1:0] r_err;
    logic       r_spa;
    logic       r_tranca;
    logic       r_alarme;
    logic       r_b_q;

    logic [1:0] w_state_nx;
    logic [1:0] w_err_nx;
    logic       w_spa_nx;
    logic       w_tranca_nx;
    logic       w_alarme_nx;
    logic       w_press;
    logic       w_lockout_done;
    logic [2:0] w_err_inc;

    // A held button counts once: only the rising edge is a press
    assign w_press   = bus.B & ~r_b_q;
    // One extra bit so the increment can be compared against MAX_ERRORS safely
    assign w_err_inc = {1'b0, r_err} + 3'd1;

`ifdef LOCKOUT_TIMER_EN
    localparam int c_TIMER_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [c_TIMER_W-1:0] r_timer;

    assign w_lockout_done = (r_state == c_ST_BL) &&
                            (r_timer == c_TIMER_W'(LOCKOUT_CYCLES - 1));

    // Held at zero outside BL so every entry into BL starts a fresh count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if ((r_state != c_ST_BL) || w_lockout_done) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    // No auto-release: BL is left only through reset
    assign w_lockout_done = 1'b0;
`endif

    // State register with the registered outputs and button history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_AB;
            r_err    <= 2'd0;
            r_spa    <= 1'b0;
            r_tranca <= 1'b0;
            r_alarme <= 1'b0;
            r_b_q    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_err    <= w_err_nx;
            r_spa    <= w_spa_nx;
            r_tranca <= w_tranca_nx;
            r_alarme <= w_alarme_nx;
            r_b_q    <= bus.B;
        end
    end

    // Next-state logic: open/close/verify/lockout sequencing
    always_comb begin
        w_state_nx = r_state;
        w_err_nx   = r_err;
        w_spa_nx   = r_spa;
        case (r_state)
            c_ST_AB: begin
                if (!r_spa) begin
                    // First press programs the password; closing needs one
                    if (w_press) begin
                        w_spa_nx = 1'b1;
                    end
                end else if (bus.FECHAR) begin
                    // Close wins over a simultaneous press
                    w_state_nx = c_ST_FE;
                    w_err_nx   = 2'd0;
                end
            end
            c_ST_FE: begin
                if (w_press) begin
                    if (bus.senha_ok) begin
                        w_state_nx = c_ST_AB;
                        w_err_nx   = 2'd0;
                    end else if (w_err_inc >= {1'b0, c_MAX_ERR}) begin
                        w_state_nx = c_ST_BL;
                        w_err_nx   = c_MAX_ERR;
                    end else begin
                        w_err_nx   = w_err_inc[1:0];
                    end
                end
            end
            c_ST_BL: begin
                if (w_lockout_done) begin
                    w_state_nx = c_ST_FE;
                    w_err_nx   = 2'd0;
                end
            end
            default: begin
                // Corrupted encoding: fail safe into the locked-out state
                w_state_nx = c_ST_BL;
            end
        endcase
    end

    // Output decode from the next state, captured alongside it
    always_comb begin
        w_tranca_nx = (w_state_nx != c_ST_AB);
        w_alarme_nx = (w_state_nx == c_ST_BL);
    end

    assign bus.state       = r_state;
    assign bus.error_count = r_err;
    assign bus.SPA         = r_spa;
    assign bus.tranca      = r_tranca;
    assign bus.alarme      = r_alarme;

endmodule
`default_nettype wire
